// File: rtl/sc_player2_pos_shifter_pkg.sv
// ---------------------------------------------------------------------------
// sc_player2_pos_shifter_pkg
// Shared definitions for the player-2 position datapath. The position
// comparator and the matrix driver import this same package, so they share
// one definition of:
//   - gameState_e  : game FSM state encoding (IDLE=00, PLAY=01, CRASH=10)
//   - startOneHot  : builds the one-hot start position from a bit index
// ---------------------------------------------------------------------------
package sc_player2_pos_shifter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PLAY  = 2'b01,
    CRASH = 2'b10
  } gameState_e;

  // The result is a wide one-hot word. Each user slices off the low bits it
  // needs, so the function works for any row width up to 64 cells.
  function automatic logic [63:0] startOneHot(input int unsigned index);
    startOneHot = 64'd1 << index;
  endfunction

endpackage

// File: rtl/sc_player2_pos_shifter_edge.sv
// ---------------------------------------------------------------------------
// sc_button_edge_detector
// Turns a synchronised level input into a single-cycle press strobe. A
// one-bit history register holds the previous-cycle level. The strobe is
// level AND NOT history, so a held button produces exactly one press.
// Ports:
//   clock  in  1  rising-edge clock
//   reset  in  1  synchronous active-high reset, clears the history
//   level  in  1  synchronised button/request level
//   press  out 1  high for the first cycle the level is seen high
// ---------------------------------------------------------------------------
module sc_button_edge_detector (
  input  logic clock,
  input  logic reset,
  input  logic level,
  output logic press
);

  logic prevLevel;

  // The history clears on reset, so a button still held when reset is
  // released counts as a fresh press.
  always_ff @(posedge clock) begin
    if (reset) begin
      prevLevel <= 1'b0;
    end else begin
      prevLevel <= level;
    end
  end

  assign press = level & ~prevLevel;

endmodule

// File: rtl/sc_player2_pos_shifter.sv
// ---------------------------------------------------------------------------
// sc_player2_pos_shifter
// Holds player 2's one-hot horizontal position on the LED-matrix row. It
// turns left/right button presses into single-cell shifts while a three-state
// game FSM (IDLE, PLAY, CRASH) is in PLAY. The crash input is fed back from
// the position comparator.
//
// Configuration macro:
//   SC_PLAYER2_POS_WRAP_EN  defined   -> moves at the row edges wrap around
//                                        and give a moved pulse
//                           undefined -> moves at the row edges saturate
//                                        (hold, no pulse)
//
// Parameters:
//   POS_DATAWIDTH    row width in cells and width of the position bus
//   POS_START_INDEX  bit set after reset and on every game (re)start
//
// Ports:
//   sc_player2_pos_CLOCK_50        in  1  50 MHz clock, rising edge
//   sc_player2_pos_RESET_InHigh    in  1  synchronous active-high reset
//   sc_player2_pos_start_InHigh    in  1  start/restart request (level)
//   sc_player2_pos_left_InHigh     in  1  move-left button (synchronised level)
//   sc_player2_pos_right_InHigh    in  1  move-right button (synchronised level)
//   sc_player2_pos_crash_InHigh    in  1  collision flag from the comparator
//   sc_player2_pos_posjug2_OutBUS  out W  one-hot player position
//   sc_player2_pos_state_OutBUS    out 2  FSM state (00 IDLE, 01 PLAY, 10 CRASH)
//   sc_player2_pos_moved_OutLow    out 1  active-low one-cycle pulse after a move
// ---------------------------------------------------------------------------
module sc_player2_pos_shifter
  import sc_player2_pos_shifter_pkg::*;
#(
  parameter int POS_DATAWIDTH   = 8,
  parameter int POS_START_INDEX = 4
) (
  input  logic                     sc_player2_pos_CLOCK_50,
  input  logic                     sc_player2_pos_RESET_InHigh,
  input  logic                     sc_player2_pos_start_InHigh,
  input  logic                     sc_player2_pos_left_InHigh,
  input  logic                     sc_player2_pos_right_InHigh,
  input  logic                     sc_player2_pos_crash_InHigh,
  output logic [POS_DATAWIDTH-1:0] sc_player2_pos_posjug2_OutBUS,
  output logic [1:0]               sc_player2_pos_state_OutBUS,
  output logic                     sc_player2_pos_moved_OutLow
);

  localparam logic [63:0]              START_WIDE = startOneHot(POS_START_INDEX);
  localparam logic [POS_DATAWIDTH-1:0] START_POS  = START_WIDE[POS_DATAWIDTH-1:0];

  logic clock;
  logic reset;
  assign clock = sc_player2_pos_CLOCK_50;
  assign reset = sc_player2_pos_RESET_InHigh;

  logic startPress;
  logic leftPress;
  logic rightPress;

  sc_button_edge_detector startEdge (
    .clock (clock),
    .reset (reset),
    .level (sc_player2_pos_start_InHigh),
    .press (startPress)
  );

  sc_button_edge_detector leftEdge (
    .clock (clock),
    .reset (reset),
    .level (sc_player2_pos_left_InHigh),
    .press (leftPress)
  );

  sc_button_edge_detector rightEdge (
    .clock (clock),
    .reset (reset),
    .level (sc_player2_pos_right_InHigh),
    .press (rightPress)
  );

  gameState_e               state;
  gameState_e               nextState;
  logic [POS_DATAWIDTH-1:0] pos;
  logic [POS_DATAWIDTH-1:0] nextPos;
  logic                     movedN;
  logic                     nextMovedN;

  // State, position and the moved strobe register together. The position
  // therefore changes on the same edge that samples the press, and the
  // moved pulse appears in the same cycle as the new position.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      pos    <= START_POS;
      movedN <= 1'b1;
    end else begin
      state  <= nextState;
      pos    <= nextPos;
      movedN <= nextMovedN;
    end
  end

  // Next-state and move decode. A start press wins over everything, including
  // a crash flag still asserted in CRASH. In PLAY, a crash wins over a move in
  // the same cycle. A move only counts as one when exactly one direction was
  // pressed. Only a real position change from a move drives the moved
  // strobe low. Reloads never pulse.
  always_comb begin
    nextState  = state;
    nextPos    = pos;
    nextMovedN = 1'b1;

    unique case (state)
      IDLE: begin
        if (startPress) begin
          nextState = PLAY;
          nextPos   = START_POS;
        end
      end

      PLAY: begin
        if (startPress) begin
          nextPos = START_POS;
        end else if (sc_player2_pos_crash_InHigh) begin
          nextState = CRASH;
        end else if (leftPress && !rightPress) begin
          if (pos[POS_DATAWIDTH-1]) begin
`ifdef SC_PLAYER2_POS_WRAP_EN
            nextPos    = {pos[POS_DATAWIDTH-2:0], pos[POS_DATAWIDTH-1]};
            nextMovedN = 1'b0;
`else
            nextPos    = pos;
`endif
          end else begin
            nextPos    = pos << 1;
            nextMovedN = 1'b0;
          end
        end else if (rightPress && !leftPress) begin
          if (pos[0]) begin
`ifdef SC_PLAYER2_POS_WRAP_EN
            nextPos    = {pos[0], pos[POS_DATAWIDTH-1:1]};
            nextMovedN = 1'b0;
`else
            nextPos    = pos;
`endif
          end else begin
            nextPos    = pos >> 1;
            nextMovedN = 1'b0;
          end
        end
      end

      CRASH: begin
        if (startPress) begin
          nextState = PLAY;
          nextPos   = START_POS;
        end
      end

      default: begin
        nextState = IDLE;
        nextPos   = START_POS;
      end
    endcase
  end

  assign sc_player2_pos_posjug2_OutBUS = pos;
  assign sc_player2_pos_state_OutBUS   = state;
  assign sc_player2_pos_moved_OutLow   = movedN;

endmodule

// File: tb/tb_sc_player2_pos_shifter.sv
// ---------------------------------------------------------------------------
// tb_sc_player2_pos_shifter
// Self-checking bench for sc_player2_pos_shifter. Stimulus is applied on the
// falling edge. A reference model tracks the player as a cell index and the
// game as a state number. It pushes the expected post-edge outputs into a
// queue. A separate monitor pops one entry after every rising edge and
// compares position, state and the moved strobe.
// Follows SC_PLAYER2_POS_WRAP_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_sc_player2_pos_shifter;

  localparam int W         = 8;
  localparam int START_IDX = 4;
`ifdef SC_PLAYER2_POS_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] pos;
    logic [1:0]   state;
    logic         movedN;
    string        tag;
  } expect_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         left = 1'b0;
  logic         right = 1'b0;
  logic         crash = 1'b0;
  logic [W-1:0] posOut;
  logic [1:0]   stateOut;
  logic         movedOut;

  expect_t expQ[$];
  int      errors = 0;
  int      checks = 0;

  // Reference model variables: cell index, game state number (0 idle,
  // 1 play, 2 crash), previous input levels, expected strobe.
  int      mIdx = START_IDX;
  int      mState = 0;
  bit      mPrevS = 0, mPrevL = 0, mPrevR = 0;
  bit      mMovedN = 1;
  string   curTag = "reset";

  sc_player2_pos_shifter #(
    .POS_DATAWIDTH   (W),
    .POS_START_INDEX (START_IDX)
  ) dut (
    .sc_player2_pos_CLOCK_50       (clk),
    .sc_player2_pos_RESET_InHigh   (rst),
    .sc_player2_pos_start_InHigh   (start),
    .sc_player2_pos_left_InHigh    (left),
    .sc_player2_pos_right_InHigh   (right),
    .sc_player2_pos_crash_InHigh   (crash),
    .sc_player2_pos_posjug2_OutBUS (posOut),
    .sc_player2_pos_state_OutBUS   (stateOut),
    .sc_player2_pos_moved_OutLow   (movedOut)
  );

  always #5 clk = ~clk;

  // Game rules at the behavioural level: presses are rising levels, start
  // wins everywhere, crash ends a game, and exactly one pressed direction
  // moves one cell. At the edges the move saturates or wraps.
  task automatic modelStep(input bit r, input bit s, input bit l, input bit rt, input bit c);
    bit sp, lp, rp;
    if (r) begin
      mIdx = START_IDX; mState = 0; mMovedN = 1;
      mPrevS = 0; mPrevL = 0; mPrevR = 0;
      return;
    end
    sp = s && !mPrevS;
    lp = l && !mPrevL;
    rp = rt && !mPrevR;
    mMovedN = 1;
    if (mState == 1) begin
      if (sp) mIdx = START_IDX;
      else if (c) mState = 2;
      else if (lp && !rp) begin
        if (mIdx < W - 1) begin mIdx = mIdx + 1; mMovedN = 0; end
        else if (WRAP) begin mIdx = 0; mMovedN = 0; end
      end else if (rp && !lp) begin
        if (mIdx > 0) begin mIdx = mIdx - 1; mMovedN = 0; end
        else if (WRAP) begin mIdx = W - 1; mMovedN = 0; end
      end
    end else if (sp) begin
      mState = 1;
      mIdx   = START_IDX;
    end
    mPrevS = s; mPrevL = l; mPrevR = rt;
  endtask

  task automatic applyStimulus(input bit r, input bit s, input bit l, input bit rt, input bit c);
    expect_t e;
    @(negedge clk);
    rst = r; start = s; left = l; right = rt; crash = c;
    modelStep(r, s, l, rt, c);
    e.pos    = W'(1) << mIdx;
    e.state  = 2'(mState);
    e.movedN = mMovedN;
    e.tag    = curTag;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input expect_t e);
    checks++;
    if (posOut !== e.pos) begin
      errors++;
      $display("[TB] FAIL %s pos: got %b expected %b", e.tag, posOut, e.pos);
    end
    checks++;
    if (stateOut !== e.state) begin
      errors++;
      $display("[TB] FAIL %s state: got %b expected %b", e.tag, stateOut, e.state);
    end
    checks++;
    if (movedOut !== e.movedN) begin
      errors++;
      $display("[TB] FAIL %s moved: got %b expected %b", e.tag, movedOut, e.movedN);
    end
  endtask

  // Monitor: the DUT presents fresh outputs after every rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
  endtask

  initial begin
    int waitCycles;
    curTag = "reset";
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    curTag = "idleHold";
    idle(20);

    curTag = "startLeftHeld";
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);

    curTag = "rightToEdge";
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0);
    end
    curTag = "rightAtLsb";
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0);

    curTag = "crashWithLeft";
    applyStimulus(0, 0, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    curTag = "crashIgnoresMoves";
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);

    curTag = "startBeatsCrash";
    applyStimulus(0, 1, 0, 0, 1);
    curTag = "crashReevaluated";
    applyStimulus(0, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);

    curTag = "restartAndLeft";
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);
    end
    curTag = "bothPressed";
    applyStimulus(0, 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 0);
    curTag = "resetMidPlay";
    applyStimulus(1, 0, 0, 0, 0);
    curTag = "heldAfterReset";
    applyStimulus(0, 1, 1, 0, 0);
    applyStimulus(0, 1, 1, 0, 0);
    idle(2);

    curTag = "random";
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 199) == 0),
                    ($urandom_range(0, 19) == 0),
                    1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 24) == 0));
    end

    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 10) begin
      @(posedge clk);
      waitCycles++;
    end
    #2;
    if (expQ.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
